// File: rtl/noc_pkg.sv
// noc_pkg: packet field layout helpers and decoder FSM states shared by the neuron receive path
package noc_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, DECODE} dec_state_t;
   function automatic int flits(input int packet_size, input int flit_size);
      return packet_size / flit_size;
   endfunction
   function automatic int y_lsb(input int x_len);
      return x_len;
   endfunction
   function automatic int axon_lsb(input int x_len, input int y_len);
      return x_len + y_len;
   endfunction
endpackage

// File: rtl/flit_assembler.sv
// flit_assembler: places flits LS-first into the packet register and flags the last accepted flit
module flit_assembler
   import noc_pkg::*;
#(
   parameter int FLIT_SIZE = 4,
   parameter int PACKET_SIZE = 32
) (
   input  logic                   neuron_clk,
   input  logic                   rst_n,
   input  logic                   accept,
   input  logic [FLIT_SIZE-1:0]   flit_data,
   output logic [PACKET_SIZE-1:0] packet,
   output logic                   packet_done,
   output logic                   partial
);
   localparam int FLITS = flits(PACKET_SIZE, FLIT_SIZE);
   localparam int CW = FLITS > 1 ? $clog2(FLITS) : 1;
   logic [CW-1:0] flit_cnt;
   assign packet_done = accept && flit_cnt == CW'(FLITS - 1);
   assign partial = flit_cnt != '0;
   always_ff @(posedge neuron_clk or negedge rst_n)
      if (!rst_n) begin
         flit_cnt <= '0;
         packet <= '0;
      end else if (accept) begin
         flit_cnt <= packet_done ? '0 : flit_cnt + CW'(1);
         packet[flit_cnt*FLIT_SIZE +: FLIT_SIZE] <= flit_data;
      end
endmodule

// File: rtl/spike_packet_decoder.sv
// spike_packet_decoder: reassembles flits, filters by destination and double-buffers per-timestep axon spikes
module spike_packet_decoder
   import noc_pkg::*;
#(
   parameter int FLIT_SIZE = 4,
   parameter int PACKET_SIZE = 32,
   parameter int X_ADDRESS_LENGTH = 8,
   parameter int Y_ADDRESS_LENGTH = 8,
   parameter int NUM_AXONS = 256,
   parameter int AXON_CNT_BIT_WIDTH = 8,
   parameter int CHECK_DEST = 1,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                        neuron_clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [FLIT_SIZE-1:0]        flit_data,
   input  logic                        flit_valid,
   output logic                        flit_ready,
   input  logic [X_ADDRESS_LENGTH-1:0] local_x,
   input  logic [Y_ADDRESS_LENGTH-1:0] local_y,
   output logic [NUM_AXONS-1:0]        spike,
   output logic                        spike_valid,
   output logic [DROP_CNT_WIDTH-1:0]   drop_cnt,
   output logic                        busy
);
   localparam int XL = X_ADDRESS_LENGTH;
   localparam int YL = y_lsb(X_ADDRESS_LENGTH);
   localparam int AL = axon_lsb(X_ADDRESS_LENGTH, Y_ADDRESS_LENGTH);
   localparam int A = AXON_CNT_BIT_WIDTH;
   dec_state_t state;
   logic [PACKET_SIZE-1:0] packet;
   logic packet_done, partial, accept, decode, keep, unused_bits;
   logic [XL-1:0] dest_x;
   logic [Y_ADDRESS_LENGTH-1:0] dest_y;
   logic [A-1:0] axon_id;
   logic [NUM_AXONS-1:0] accum, hit;
   assign flit_ready = state == COLLECT;
   assign accept = flit_valid && flit_ready;
   assign decode = state == DECODE;
   assign busy = partial || decode;
   assign dest_x = packet[XL-1:0];
   assign dest_y = packet[AL-1:YL];
   assign axon_id = packet[AL+A-1:AL];
   assign unused_bits = ^packet[PACKET_SIZE-1:AL+A];
   assign keep = (CHECK_DEST == 0 || (dest_x == local_x && dest_y == local_y)) && 32'(axon_id) < NUM_AXONS;
   assign hit = decode && keep ? NUM_AXONS'(1) << axon_id : '0;
   flit_assembler #(.FLIT_SIZE(FLIT_SIZE), .PACKET_SIZE(PACKET_SIZE)) u_asm (
      .neuron_clk(neuron_clk),
      .rst_n(rst_n),
      .accept(accept),
      .flit_data(flit_data),
      .packet(packet),
      .packet_done(packet_done),
      .partial(partial)
   );
   always_ff @(posedge neuron_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state == COLLECT && packet_done ? DECODE : COLLECT;
   // a decode landing on the start edge is folded into the closing snapshot
   always_ff @(posedge neuron_clk or negedge rst_n)
      if (!rst_n) begin
         accum <= '0;
         spike <= '0;
         spike_valid <= 1'b0;
         drop_cnt <= '0;
      end else begin
         accum <= start ? '0 : accum | hit;
         if (start) spike <= accum | hit;
         spike_valid <= start;
         if (decode && !keep && !(&drop_cnt)) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
endmodule

// File: tb/tb_spike_packet_decoder.sv
// tb_spike_packet_decoder: scoreboarded snapshots plus direct checks of drops, handshake and reset
module tb_spike_packet_decoder;
   logic neuron_clk = 0, rst_n = 0, start = 0, flit_valid = 0;
   logic [3:0] flit_data = 0;
   logic [7:0] local_x = 8'd3, local_y = 8'd5;
   logic flit_ready, spike_valid, busy, flit_ready2, spike_valid2, busy2;
   logic [255:0] spike, spike2;
   logic [7:0] drop_cnt, drop_cnt2;
   logic [255:0] sb_q[$];
   logic [255:0] model_accum = '0;
   logic [255:0] one = 256'd1;
   int model_drop = 0, total = 0, bad = 0;
   always #5 neuron_clk = ~neuron_clk;
   spike_packet_decoder dut (
      .neuron_clk(neuron_clk), .rst_n(rst_n), .start(start), .flit_data(flit_data),
      .flit_valid(flit_valid), .flit_ready(flit_ready), .local_x(local_x), .local_y(local_y),
      .spike(spike), .spike_valid(spike_valid), .drop_cnt(drop_cnt), .busy(busy)
   );
   spike_packet_decoder #(.CHECK_DEST(0)) dut2 (
      .neuron_clk(neuron_clk), .rst_n(rst_n), .start(start), .flit_data(flit_data),
      .flit_valid(flit_valid), .flit_ready(flit_ready2), .local_x(local_x), .local_y(local_y),
      .spike(spike2), .spike_valid(spike_valid2), .drop_cnt(drop_cnt2), .busy(busy2)
   );
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] a);
      return {8'h00, a, y, x};
   endfunction
   task automatic send_flit(input logic [3:0] d);
      int n = 0;
      flit_data = d;
      flit_valid = 1;
      while (!flit_ready && n < 20) begin
         @(negedge neuron_clk);
         n++;
      end
      if (!flit_ready) check("ready_timeout", flit_ready, 1);
      @(negedge neuron_clk);
   endtask
   task automatic send_flits(input logic [31:0] p, input int lo, input int hi);
      for (int k = lo; k < hi; k++) send_flit(p[k*4 +: 4]);
      flit_valid = 0;
      if (hi == 8) begin
         if (p[7:0] == 8'd3 && p[15:8] == 8'd5) model_accum[p[23:16]] = 1'b1;
         else if (model_drop < 255) model_drop++;
      end
   endtask
   task automatic pulse_start();
      sb_q.push_back(model_accum);
      model_accum = '0;
      start = 1;
      @(negedge neuron_clk);
      start = 0;
   endtask
   always @(negedge neuron_clk)
      if (rst_n && spike_valid) begin
         if (sb_q.size() == 0) check("spurious_valid", spike_valid, 0);
         else check("snapshot", spike, sb_q.pop_front());
      end
   initial begin
      repeat (2) @(negedge neuron_clk);
      check("rst_spike", spike, 0);
      check("rst_valid", spike_valid, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_ready", flit_ready, 0);
      check("rst_busy", busy, 0);
      rst_n = 1;
      @(negedge neuron_clk);
      check("ready_rise", flit_ready, 1);
      send_flits(32'h002A0503, 0, 8);
      check("ready_decode", flit_ready, 0);
      check("busy_decode", busy, 1);
      @(negedge neuron_clk);
      check("ready_after", flit_ready, 1);
      check("busy_idle", busy, 0);
      pulse_start();
      check("drop_none", drop_cnt, model_drop);
      @(negedge neuron_clk);
      check("valid_fall", spike_valid, 0);
      send_flits(pkt(4, 5, 7), 0, 8);
      @(negedge neuron_clk);
      check("drop_one", drop_cnt, model_drop);
      pulse_start();
      check("nocheck_spike", spike2, one << 7);
      send_flits(pkt(3, 5, 42), 0, 8);
      send_flits(pkt(3, 5, 42), 0, 8);
      send_flits(pkt(3, 5, 0), 0, 8);
      @(negedge neuron_clk);
      check("dup_nodrop", drop_cnt, model_drop);
      pulse_start();
      pulse_start();
      send_flits(pkt(3, 5, 9), 0, 8);
      pulse_start();
      send_flits(pkt(3, 5, 11), 0, 3);
      check("split_busy", busy, 1);
      pulse_start();
      send_flits(pkt(3, 5, 11), 3, 8);
      @(negedge neuron_clk);
      pulse_start();
      for (int i = 0; i < 300; i++) send_flits(pkt(0, 0, 0), 0, 8);
      @(negedge neuron_clk);
      check("sat_reach", drop_cnt, model_drop);
      send_flits(pkt(0, 0, 0), 0, 8);
      @(negedge neuron_clk);
      check("sat_hold", drop_cnt, model_drop);
      send_flits(pkt(3, 5, 1), 0, 5);
      rst_n = 0;
      #1;
      check("arst_spike", spike, 0);
      check("arst_valid", spike_valid, 0);
      check("arst_drop", drop_cnt, 0);
      check("arst_ready", flit_ready, 0);
      check("arst_busy", busy, 0);
      model_accum = '0;
      model_drop = 0;
      sb_q.delete();
      @(negedge neuron_clk);
      rst_n = 1;
      @(negedge neuron_clk);
      send_flits(pkt(3, 5, 1), 0, 8);
      @(negedge neuron_clk);
      check("post_rst_busy", busy, 0);
      pulse_start();
      check("post_rst_drop", drop_cnt, model_drop);
      @(negedge neuron_clk);
      check("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spike_packet_decoder.md
# spike_packet_decoder

Neuron-side receive block. It sits between the read port of the router-to-neuron CDC flit FIFO and the neuron core, entirely in the neuron_clk domain. It reassembles flits into packets and optionally filters them by destination address. Valid spikes accumulate into an axon-indexed vector for the current timestep, and that vector is handed to the core as a stable snapshot on each `start` pulse.

## Interface
Parameters:
- FLIT_SIZE, 4, flit width in bits
- PACKET_SIZE, 32, packet width; must be an integer multiple of FLIT_SIZE
- X_ADDRESS_LENGTH, 8, destination-x field width
- Y_ADDRESS_LENGTH, 8, destination-y field width
- NUM_AXONS, 256, spike vector width
- AXON_CNT_BIT_WIDTH, 8, axon-id field width
- CHECK_DEST, 1, 1 = drop packets whose destination is not (local_x, local_y); 0 = accept all
- DROP_CNT_WIDTH, 8, drop counter width

Ports:
- neuron_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  timestep boundary, single-cycle pulse
- flit_data  in  FLIT_SIZE  flit from CDC FIFO
- flit_valid  in  1  flit_data valid (FIFO not empty)
- flit_ready  out  1  flit accepted on the edge where valid&ready
- local_x  in  X_ADDRESS_LENGTH  this neuron's x address (quasi-static)
- local_y  in  Y_ADDRESS_LENGTH  this neuron's y address (quasi-static)
- spike  out  NUM_AXONS  spike snapshot of the last completed timestep
- spike_valid  out  1  one-cycle pulse when spike has just been updated
- drop_cnt  out  DROP_CNT_WIDTH  saturating count of dropped packets
- busy  out  1  a packet is partially assembled or being decoded

## Operation
- FLITS = PACKET_SIZE/FLIT_SIZE. Flits arrive least-significant first: flit k fills bits [k*FLIT_SIZE +: FLIT_SIZE].
- Packet fields:
  - dest_x = [X-1:0]
  - dest_y = [X+Y-1:X]
  - axon_id = [X+Y+A-1:X+Y]
  - Upper bits are ignored.
- FSM states:
  - IDLE (reset state): flit_ready=0. Goes to COLLECT unconditionally on the next edge.
  - COLLECT: flit_ready=1. Each accepted flit increments flit_cnt. Acceptance of flit FLITS-1 → DECODE, flit_cnt ← 0.
  - DECODE: flit_ready=0, one cycle. Classifies the packet, then → COLLECT.
- Classification in DECODE:
  - Drop if CHECK_DEST=1 and (dest_x≠local_x or dest_y≠local_y).
  - Drop if axon_id ≥ NUM_AXONS.
  - Otherwise accum[axon_id] ← 1.
  - A drop increments drop_cnt, saturating at all-ones.
- Duplicate spikes to the same axon within one timestep OR together and are not counted.
- On start:
  - spike ← accum | (bit set by a DECODE in the same cycle).
  - accum ← 0.
  - spike_valid=1 for the following cycle.
- A DECODE coinciding with start belongs to the closing timestep.
- A packet partially assembled across start is unaffected and credited to the timestep in which its DECODE occurs.
- start while accum=0 still produces spike=0 and a spike_valid pulse.
- busy = (flit_cnt≠0) or state==DECODE.

## Timing
- Reset values: spike=0, spike_valid=0, drop_cnt=0, flit_ready=0, busy=0, accum=0, flit_cnt=0, state=IDLE.
- flit_ready rises on the first edge after rst_n deasserts.
- Throughput: one packet per FLITS+1 cycles with flit_valid held high.
- Latency: the last flit is accepted at edge N, DECODE occurs in cycle N..N+1, and accum is updated at edge N+1. The bit appears on spike at the first start-sampling edge ≥ N+1.
- flit_valid gaps stall assembly indefinitely with no timeout. flit_data is ignored when flit_valid=0 or flit_ready=0.
- rst_n assertion mid-packet discards the partial packet and all state asynchronously.
- All outputs are registered except flit_ready and busy, which decode from registered state.

## Structure
- Shared package `noc_pkg`:
  - packet field offsets and widths (X/Y/axon)
  - the FSM state enum (IDLE/COLLECT/DECODE)
  - the FLITS derivation
- Sub-module `flit_assembler`: flit counter, shift/insert into the packet register, and the packet_done pulse. It owns FLITS-related logic.
- The top level holds the FSM, classification, accum/spike double buffer and drop counter. Target RTL is about 200 lines.

## Test plan
Defaults throughout, local=(3,5).
- Packet 0x002A0503, sent as flits 3,0,5,0,A,2,0,0 back-to-back, then start → spike has only bit 42 set, spike_valid one cycle, drop_cnt=0; flit_ready low exactly in the DECODE cycle.
- Packet with dest (4,5), axon 7 → dropped, drop_cnt=1, spike stays 0 after start. Same packet with CHECK_DEST=0 → bit 7 set.
- Axon 42 twice plus axon 0 in one timestep, then start, then start again → first snapshot has bits {0,42}; second snapshot is 0 with spike_valid still pulsing.
- start asserted in the DECODE cycle of axon 9 → bit 9 appears in that snapshot, not the next. Packet split by start after 3 flits → credited to the next snapshot.
- 300 packets to (0,0), then one more → drop_cnt=255 and it saturates.
- rst_n pulsed after 5 flits of a packet → all outputs 0. A subsequent clean 8-flit packet for axon 1 decodes correctly with no leftover flits.
